// File: rtl/calc_pkg.sv
// Shared constants and types for the ALU result display path.
// Holds the converter FSM encoding, BCD digit constants and the default
// data widths used by both the converter and the display stage.
package calc_pkg;

  // Converter FSM: idle, or running one shift/add-3 iteration per clock.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  // Default ALU result width and matching number of decimal digits.
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  // Conditional +3 on a single 4-bit digit.
  always_comb begin
    q = d;
    if (d >= BCD_DIGIT_W'(ADD3_THRESH)) begin
      q = d + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one iteration per clock.
// Handshake: start is honoured only in IDLE; busy is high while iterating;
// done pulses for one cycle when bcd_out/flag_out/sign_out have just been
// loaded. Outputs hold their last result until the next completed conversion.
// Optional build macro BIN_TO_BCD_SIGNED_EN: treat bin_in as two's complement,
// convert its magnitude and report the sign on sign_out (otherwise sign_out=0).
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            bin_in,
  input  logic                        flag_in,
  output logic                        busy,
  output logic                        done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                        flag_out,
  output logic                        sign_out
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   bin_sr;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scratch_adj;
  logic [SCR_W-1:0]   scratch_shf;
  logic               flag_q;
  logic               sign_q;
  logic               accept;
  logic               last_iter;
  logic               cap_sign;
  logic [WIDTH-1:0]   cap_mag;

  assign accept    = (state == ST_IDLE) && start;
  assign last_iter = (state == ST_SHIFT) && (cnt == CNT_W'(WIDTH - 1));

  // Value loaded into the shift register at an accepted start.
`ifdef BIN_TO_BCD_SIGNED_EN
  // Magnitude wraps in WIDTH bits, so the most negative input maps to 2^(WIDTH-1).
  always_comb begin
    cap_sign = bin_in[WIDTH-1];
    cap_mag  = cap_sign ? (~bin_in + WIDTH'(1)) : bin_in;
  end
`else
  always_comb begin
    cap_sign = 1'b0;
    cap_mag  = bin_in;
  end
`endif

  // Add-3 adjust on every digit before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Shift {adjusted scratch, binary} left by one: binary MSB enters the units digit.
  assign scratch_shf = {scratch_adj[SCR_W-2:0], bin_sr[WIDTH-1]};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM next state: leave IDLE on start, return after the last iteration.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)     state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_iter) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in SHIFT, publish results on the last iteration.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      bin_sr   <= '0;
      scratch  <= '0;
      flag_q   <= 1'b0;
      sign_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      flag_out <= 1'b0;
      sign_out <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        bin_sr  <= cap_mag;
        scratch <= '0;
        flag_q  <= flag_in;
        sign_q  <= cap_sign;
        cnt     <= '0;
        busy    <= 1'b1;
      end else if (state == ST_SHIFT) begin
        scratch <= scratch_shf;
        bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
        cnt     <= cnt + CNT_W'(1);
        if (last_iter) begin
          bcd_out  <= scratch_shf;
          flag_out <= flag_q;
          sign_out <= sign_q;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: reset state, conversions with known BCD
// results, latency, ignored starts while busy, start on the done cycle,
// reset abort and result hold. Build with BIN_TO_BCD_SIGNED_EN to run the
// two's-complement vectors instead of the unsigned 16'hFFFF vector.
module tb_bin_to_bcd_seq;
  import calc_pkg::*;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin_in = '0;
  logic        flag_in = 1'b0;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
  logic        flag_out;
  logic        sign_out;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .flag_in  (flag_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .flag_out (flag_out),
    .sign_out (sign_out)
  );

  // Scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [19:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drivers: inputs change on the falling edge, outputs sampled there too.
  task automatic start_conv(input logic [15:0] val, input logic flg, input logic [19:0] exp_bcd);
    start   = 1'b1;
    bin_in  = val;
    flag_in = flg;
    exp_q.push_back(exp_bcd);
    @(negedge clk);
    start   = 1'b0;
    bin_in  = 16'($urandom_range(0, 65535));
    flag_in = ~flg;
    check_eq("busy_after_start", busy, 1);
    check_eq("done_after_start", done, 0);
  endtask

  // Waits for done (bounded), optionally pulsing start at two cycle offsets after capture.
  task automatic wait_done(input int noise_a, input int noise_b, input logic exp_flag,
                           input logic exp_sign);
    int          k = 0;
    int          busy_low = 0;
    bit          seen = 0;
    logic [19:0] exp_bcd;
    while (k < 40 && !seen) begin
      start  = ((k + 1) == noise_a) || ((k + 1) == noise_b);
      bin_in = 16'($urandom_range(0, 65535));
      @(negedge clk);
      k++;
      if (done) seen = 1;
      else if (!busy) busy_low++;
    end
    start = 1'b0;
    check_eq("latency", k, 16);
    check_eq("busy_gap", busy_low, 0);
    check_eq("busy_at_done", busy, 0);
    exp_bcd = exp_q.pop_front();
    check_eq("bcd_out", bcd_out, exp_bcd);
    check_eq("flag_out", flag_out, exp_flag);
    check_eq("sign_out", sign_out, exp_sign);
  endtask

  // Idle cycles with wandering bin_in; result must hold and done stay low.
  task automatic idle_hold(input int n, input logic [19:0] exp_bcd);
    int done_seen = 0;
    for (int i = 0; i < n; i++) begin
      bin_in = 16'($urandom_range(0, 65535));
      @(negedge clk);
      if (done) done_seen++;
    end
    check_eq("hold_done_low", done_seen, 0);
    check_eq("hold_bcd", bcd_out, exp_bcd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;

    // Reset and idle
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_bcd", bcd_out, 20'h00000);
    check_eq("rst_flag", flag_out, 0);
    check_eq("rst_sign", sign_out, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic conversion
    start_conv(16'd1234, 1'b0, 20'h01234);
    wait_done(0, 0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("done_pulse_clears", done, 0);
    idle_hold(5, 20'h01234);

    // All ones
`ifdef BIN_TO_BCD_SIGNED_EN
    start_conv(16'hFFFF, 1'b1, 20'h00001);
    wait_done(0, 0, 1'b1, 1'b1);
    @(negedge clk);
    start_conv(16'h8000, 1'b0, 20'h32768);
    wait_done(0, 0, 1'b0, 1'b1);
    @(negedge clk);
    start_conv(16'h7FFF, 1'b1, 20'h32767);
    wait_done(0, 0, 1'b1, 1'b0);
    @(negedge clk);
`else
    start_conv(16'hFFFF, 1'b1, 20'h65535);
    wait_done(0, 0, 1'b1, 1'b0);
    @(negedge clk);
`endif

    // Starts while busy are ignored; a start on the done cycle is accepted.
    start_conv(16'd0, 1'b0, 20'h00000);
    wait_done(3, 8, 1'b0, 1'b0);
    start_conv(16'd9, 1'b1, 20'h00009);
    wait_done(0, 0, 1'b1, 1'b0);
    @(negedge clk);

    // Reset mid-conversion aborts without a done pulse.
    start_conv(16'd500, 1'b1, 20'h00500);
    repeat (6) begin
      bin_in = 16'($urandom_range(0, 65535));
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_bcd", bcd_out, 20'h00000);
    check_eq("abort_flag", flag_out, 0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_eq("abort_no_done", done_cnt, 0);

    start_conv(16'd42, 1'b0, 20'h00042);
    wait_done(0, 0, 1'b0, 1'b0);
    @(negedge clk);
    idle_hold(4, 20'h00042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
